qoa_spi_master: RTL and testbench

//  SPI mode-0 initiator that drives the decoder's slave port from a host-side command interface.

---
 rtl/qoa_spi_master.sv | 174 +++++++++++++++++
 tb/tb_qoa_spi_master.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/qoa_spi_master.sv
// qoa_spi_master: SPI mode-0 initiator that writes single bytes and reads 16-bit PCM samples.
// Optional: define SPI_MISO_SYNC_EN to pass spi_miso through a 2-flop synchronizer (CLK_DIV >= 3).
module qoa_spi_master #(
   parameter int CLK_DIV = 4
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [7:0]  cmd_data,
   input  logic        cmd_hold_cs,
   output logic        rsp_valid,
   output logic [15:0] rsp_data,
   output logic        busy,
   output logic        spi_sclk,
   output logic        spi_cs_n,
   output logic        spi_mosi,
   input  logic        spi_miso
);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      HIGH,
      LOW,
      TAIL,
      HELD,
      GAP
   } state_t;

   localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);

   state_t      state;
   logic [7:0]  div_cnt;
   logic [3:0]  bit_cnt;
   logic        is_write;
   logic        hold_cs;
   logic [7:0]  tx_shift;
   logic [15:0] rx_shift;
   logic        miso_s;
   logic        phase_end;
   logic        last_bit;
   logic        accept;

`ifdef SPI_MISO_SYNC_EN
   logic [1:0] miso_sync;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         miso_sync <= 2'b00;
      end else begin
         miso_sync <= {miso_sync[0], spi_miso};
      end
   end

   assign miso_s = miso_sync[1];

   // Two cycles of synchronizer delay must still land inside the HIGH phase.
   if (CLK_DIV < 3 || CLK_DIV > 255) begin : g_div_check
      $error("qoa_spi_master: CLK_DIV must be 3..255 with SPI_MISO_SYNC_EN");
   end
`else
   assign miso_s = spi_miso;

   if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_div_check
      $error("qoa_spi_master: CLK_DIV must be 2..255");
   end
`endif

   assign phase_end = (div_cnt == 8'd0);
   assign last_bit  = is_write ? (bit_cnt == 4'd7) : (bit_cnt == 4'd15);
   assign accept    = cmd_valid && cmd_ready;

   // Each timed phase reloads div_cnt on exit; the shared decrement stops at zero.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state     <= IDLE;
         div_cnt   <= 8'd0;
         bit_cnt   <= 4'd0;
         is_write  <= 1'b0;
         hold_cs   <= 1'b0;
         tx_shift  <= 8'd0;
         rx_shift  <= 16'd0;
         cmd_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_data  <= 16'd0;
         busy      <= 1'b0;
         spi_sclk  <= 1'b0;
         spi_cs_n  <= 1'b1;
         spi_mosi  <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         if (!phase_end) begin
            div_cnt <= div_cnt - 8'd1;
         end
         case (state)
            IDLE, HELD: begin
               if (accept) begin
                  is_write  <= cmd_write;
                  hold_cs   <= cmd_hold_cs;
                  tx_shift  <= {cmd_data[6:0], 1'b0};
                  spi_mosi  <= cmd_write & cmd_data[7];
                  spi_cs_n  <= 1'b0;
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
                  bit_cnt   <= 4'd0;
                  div_cnt   <= DIV_LOAD;
                  state     <= SETUP;
               end else begin
                  cmd_ready <= 1'b1;
               end
            end
            SETUP: begin
               if (phase_end) begin
                  spi_sclk <= 1'b1;
                  div_cnt  <= DIV_LOAD;
                  state    <= HIGH;
               end
            end
            HIGH: begin
               if (phase_end) begin
                  rx_shift <= {rx_shift[14:0], miso_s};
                  spi_sclk <= 1'b0;
                  div_cnt  <= DIV_LOAD;
                  if (last_bit) begin
                     state <= TAIL;
                  end else begin
                     bit_cnt  <= bit_cnt + 4'd1;
                     spi_mosi <= is_write & tx_shift[7];
                     tx_shift <= {tx_shift[6:0], 1'b0};
                     state    <= LOW;
                  end
               end
            end
            LOW: begin
               if (phase_end) begin
                  spi_sclk <= 1'b1;
                  div_cnt  <= DIV_LOAD;
                  state    <= HIGH;
               end
            end
            TAIL: begin
               if (phase_end) begin
                  spi_mosi <= 1'b0;
                  div_cnt  <= DIV_LOAD;
                  if (!is_write) begin
                     rsp_valid <= 1'b1;
                     rsp_data  <= rx_shift;
                  end
                  if (hold_cs) begin
                     cmd_ready <= 1'b1;
                     state     <= HELD;
                  end else begin
                     spi_cs_n <= 1'b1;
                     state    <= GAP;
                  end
               end
            end
            GAP: begin
               if (phase_end) begin
                  cmd_ready <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_qoa_spi_master.sv
// tb_qoa_spi_master: directed self-checking bench for qoa_spi_master with a mode-0 slave model.
// Build with SPI_MISO_SYNC_EN to run the same sequence at CLK_DIV=3 through the synchronizer.
module tb_qoa_spi_master;

`ifdef SPI_MISO_SYNC_EN
   localparam int N = 3;
`else
   localparam int N = 4;
`endif

   logic        sys_clk = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_write = 1'b0;
   logic [7:0]  cmd_data = 8'd0;
   logic        cmd_hold_cs = 1'b0;
   logic        rsp_valid;
   logic [15:0] rsp_data;
   logic        busy;
   logic        spi_sclk;
   logic        spi_cs_n;
   logic        spi_mosi;
   logic        spi_miso = 1'b0;

   logic [15:0] slave_word = 16'hBEEF;
   logic [15:0] slave_sh = 16'd0;
   logic        slave_cs_prev = 1'b1;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int acc_cnt, acc_cyc, rise_cnt, first_rise_cyc, last_rise_cyc, gap_bad;
   int cs_fall_cnt, cs_fall_cyc, cs_rise_cnt, cs_rise_cyc, rsp_cnt, rsp_cyc;
   int ready_busy, ready_cyc, prev_rise;
   logic [31:0] mosi_bits;
   logic mosi_seen;
   logic prev_sclk = 1'b0;
   logic prev_cs_n = 1'b1;

   qoa_spi_master #(.CLK_DIV(N)) dut (
      .sys_clk     (sys_clk),
      .sys_rst_n   (sys_rst_n),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_write   (cmd_write),
      .cmd_data    (cmd_data),
      .cmd_hold_cs (cmd_hold_cs),
      .rsp_valid   (rsp_valid),
      .rsp_data    (rsp_data),
      .busy        (busy),
      .spi_sclk    (spi_sclk),
      .spi_cs_n    (spi_cs_n),
      .spi_mosi    (spi_mosi),
      .spi_miso    (spi_miso)
   );

   always #5 sys_clk = ~sys_clk;

   // Mode-0 slave: presents the MSB when CS falls, shifts on every SCLK fall while selected.
   always @(negedge spi_cs_n or posedge spi_cs_n or negedge spi_sclk) begin
      if (!spi_cs_n) begin
         if (slave_cs_prev) begin
            slave_sh = slave_word;
         end else begin
            slave_sh = {slave_sh[14:0], 1'b0};
         end
         spi_miso = slave_sh[15];
      end
      slave_cs_prev = spi_cs_n;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_stats();
      acc_cnt = 0; acc_cyc = 0; rise_cnt = 0; first_rise_cyc = 0; last_rise_cyc = 0;
      gap_bad = 0; cs_fall_cnt = 0; cs_fall_cyc = 0; cs_rise_cnt = 0; cs_rise_cyc = 0;
      rsp_cnt = 0; rsp_cyc = 0; ready_busy = 0; ready_cyc = 0;
      mosi_bits = 32'd0; mosi_seen = 1'b0;
   endtask

   // One clock: outputs are observed on the falling edge after the active edge.
   task automatic step();
      logic acc_now;
      acc_now = cmd_valid && cmd_ready;
      @(negedge sys_clk);
      cyc++;
      if (acc_now) begin
         acc_cnt++;
         acc_cyc = cyc;
      end
      if (spi_sclk && !prev_sclk) begin
         if (rise_cnt != 0 && (cyc - last_rise_cyc) != 2 * N) gap_bad++;
         if (rise_cnt == 0) first_rise_cyc = cyc;
         last_rise_cyc = cyc;
         rise_cnt++;
         mosi_bits = {mosi_bits[30:0], spi_mosi};
      end
      if (!spi_cs_n && prev_cs_n) begin
         cs_fall_cnt++;
         cs_fall_cyc = cyc;
      end
      if (spi_cs_n && !prev_cs_n) begin
         cs_rise_cnt++;
         cs_rise_cyc = cyc;
      end
      if (rsp_valid) begin
         rsp_cnt++;
         rsp_cyc = cyc;
      end
      if (spi_mosi) mosi_seen = 1'b1;
      if (busy && cmd_ready) ready_busy++;
      prev_sclk = spi_sclk;
      prev_cs_n = spi_cs_n;
   endtask

   task automatic applyStimulus(input logic wr, input logic [7:0] data, input logic hold);
      logic got;
      got = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (cmd_ready) begin
            got = 1'b1;
            break;
         end
         step();
      end
      check("cmd_ready_reached", 32'(got), 32'd1);
      cmd_write   = wr;
      cmd_data    = data;
      cmd_hold_cs = hold;
      cmd_valid   = 1'b1;
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      logic done;
      done = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if (cmd_ready && !busy) begin
            done = 1'b1;
            break;
         end
         step();
      end
      ready_cyc = cyc;
      check("idle_reached", 32'(done), 32'd1);
   endtask

   initial begin
      clear_stats();
      repeat (3) @(negedge sys_clk);
      #1;
      check("rst_cs_n", 32'(spi_cs_n), 32'd1);
      check("rst_sclk", 32'(spi_sclk), 32'd0);
      check("rst_mosi", 32'(spi_mosi), 32'd0);
      check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_data", {16'd0, rsp_data}, 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      step();
      step();
      check("ready_after_reset", 32'(cmd_ready), 32'd1);

      $display("[TB] write 0xA5, CS released");
      clear_stats();
      applyStimulus(1'b1, 8'hA5, 1'b0);
      wait_idle();
      check("wr_cs_fall_at_accept", 32'(cs_fall_cyc - acc_cyc), 32'd0);
      check("wr_setup_len", 32'(first_rise_cyc - acc_cyc), 32'(N));
      check("wr_rise_count", 32'(rise_cnt), 32'd8);
      check("wr_rise_spacing", 32'(gap_bad), 32'd0);
      check("wr_mosi_bits", mosi_bits, 32'h0000_00A5);
      check("wr_cs_rise_latency", 32'(cs_rise_cyc - acc_cyc), 32'(17 * N));
      check("wr_ready_after_gap", 32'(ready_cyc - cs_rise_cyc), 32'(N));
      check("wr_no_rsp", 32'(rsp_cnt), 32'd0);
      check("wr_rsp_data_kept", {16'd0, rsp_data}, 32'd0);

      $display("[TB] read 0xBEEF");
      slave_word = 16'hBEEF;
      clear_stats();
      applyStimulus(1'b0, 8'hFF, 1'b0);
      wait_idle();
      check("rd_rise_count", 32'(rise_cnt), 32'd16);
      check("rd_rise_spacing", 32'(gap_bad), 32'd0);
      check("rd_rsp_pulses", 32'(rsp_cnt), 32'd1);
      check("rd_rsp_latency", 32'(rsp_cyc - acc_cyc), 32'(33 * N));
      check("rd_rsp_data", {16'd0, rsp_data}, 32'h0000_BEEF);
      check("rd_mosi_low", 32'(mosi_seen), 32'd0);

      $display("[TB] held write 0x01, write 0x02, read 0x1234");
      slave_word = 16'h1234;
      clear_stats();
      applyStimulus(1'b1, 8'h01, 1'b1);
      applyStimulus(1'b1, 8'h02, 1'b0);
      wait_idle();
      check("held_cs_falls", 32'(cs_fall_cnt), 32'd1);
      check("held_cs_rises", 32'(cs_rise_cnt), 32'd1);
      check("held_rise_count", 32'(rise_cnt), 32'd16);
      check("held_mosi_bits", mosi_bits, 32'h0000_0102);
      check("held_rsp_data_kept", {16'd0, rsp_data}, 32'h0000_BEEF);
      prev_rise = cs_rise_cyc;
      applyStimulus(1'b0, 8'h00, 1'b0);
      check("gap_cs_high_min", 32'((cs_fall_cyc - prev_rise) >= N), 32'd1);
      wait_idle();
      check("chain_rd_data", {16'd0, rsp_data}, 32'h0000_1234);
      check("chain_rsp_pulses", 32'(rsp_cnt), 32'd1);

      $display("[TB] three back-to-back writes with cmd_valid held");
      clear_stats();
      cmd_write   = 1'b1;
      cmd_hold_cs = 1'b0;
      cmd_data    = 8'h11;
      cmd_valid   = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         step();
         if (acc_cnt == 1) cmd_data = 8'h22;
         if (acc_cnt == 2) cmd_data = 8'h33;
         if (acc_cnt >= 3) break;
      end
      cmd_valid = 1'b0;
      wait_idle();
      check("b2b_accepts", 32'(acc_cnt), 32'd3);
      check("b2b_ready_while_busy", 32'(ready_busy), 32'd0);
      check("b2b_mosi_bits", mosi_bits, 32'h0011_2233);
      check("b2b_cs_rises", 32'(cs_rise_cnt), 32'd3);

      $display("[TB] reset at 5th rise of a write");
      clear_stats();
      applyStimulus(1'b1, 8'hFF, 1'b0);
      for (int i = 0; i < 200; i++) begin
         if (rise_cnt >= 5) break;
         step();
      end
      check("mid_rise_reached", 32'(rise_cnt), 32'd5);
      check("mid_mosi_before", 32'(spi_mosi), 32'd1);
      sys_rst_n = 1'b0;
      #1;
      check("mid_rst_cs_n", 32'(spi_cs_n), 32'd1);
      check("mid_rst_sclk", 32'(spi_sclk), 32'd0);
      check("mid_rst_mosi", 32'(spi_mosi), 32'd0);
      step();
      step();
      sys_rst_n = 1'b1;
      clear_stats();
      repeat (20 * N) step();
      check("post_rst_rsp", 32'(rsp_cnt), 32'd0);
      check("post_rst_rises", 32'(rise_cnt), 32'd0);
      check("post_rst_busy", 32'(busy), 32'd0);
      check("post_rst_ready", 32'(cmd_ready), 32'd1);
      check("post_rst_cs_n", 32'(spi_cs_n), 32'd1);
      check("post_rst_rsp_data", {16'd0, rsp_data}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
